// File: rtl/led_matrix_pkg.sv
// Shared types and sizes for the LED matrix display path; also imported by the game core.
package led_matrix_pkg;
  localparam int LM_COLS = 4;
  localparam int LM_ROWS = 8;

  typedef logic [LM_ROWS-1:0]         col_t;
  typedef logic [$clog2(LM_COLS)-1:0] col_idx_t;
  typedef col_t                       frame_t [LM_COLS];
endpackage

// File: rtl/led_scan_timer.sv
// Column scan timebase: slot cycle counter and column counter, plus decoded slot events.
module led_scan_timer #(
  parameter int COLS         = 4,
  parameter int COL_CYCLES   = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  output logic [$clog2(COLS)-1:0] col,
  output logic                    blank,
  output logic [2:0]              pwm_slot,
  output logic                    frame_boundary,
  output logic                    frame_start
);
  localparam int CW  = $clog2(COL_CYCLES);
  localparam int CLW = $clog2(COLS);
  localparam logic [CW-1:0]  CYC_MAX = CW'(COL_CYCLES - 1);
  localparam logic [CW-1:0]  CYC_BLK = CW'(BLANK_CYCLES);
  localparam logic [CLW-1:0] COL_MAX = CLW'(COLS - 1);

  logic [CW-1:0] cyc;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cyc <= '0;
      col <= '0;
    end else begin
      cyc <= cyc + 1'b1;
      if (cyc == CYC_MAX)
        col <= (col == COL_MAX) ? '0 : col + 1'b1;
    end
  end

  assign blank          = (cyc < CYC_BLK);
  // Top three bits of the slot counter divide the slot into eighths for duty control.
  assign pwm_slot       = cyc[CW-1 -: 3];
  assign frame_boundary = (col == COL_MAX) && (cyc == CYC_MAX);
  assign frame_start    = (col == '0) && (cyc == '0);
endmodule

// File: rtl/led_matrix_scan.sv
// Double-buffered 4x8 LED matrix column scanner with frame-aligned commit and dead-time blanking.
// Optional BRIGHTNESS_PWM_EN adds a 3-bit BRIGHTNESS input for 1/8..8/8 duty in the active window.
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int COLS         = LM_COLS,
  parameter int ROWS         = LM_ROWS,
  parameter int COL_CYCLES   = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    WR_EN,
  input  logic [$clog2(COLS)-1:0] WR_COL,
  input  logic [ROWS-1:0]         WR_DATA,
  input  logic                    COMMIT,
`ifdef BRIGHTNESS_PWM_EN
  input  logic [2:0]              BRIGHTNESS,
`endif
  output logic                    COMMIT_PENDING,
  output logic                    SWAP_DONE,
  output logic                    FRAME_START,
  output logic [ROWS-1:0]         LED_R,
  output logic [COLS-1:0]         LED_C
);
  localparam int CLW = $clog2(COLS);

  logic [CLW-1:0]  col;
  logic            blank, frame_boundary, frame_start;
  logic [2:0]      pwm_slot, level;
  logic            dark, swap;
  logic [ROWS-1:0] front [COLS];
  logic [ROWS-1:0] back  [COLS];

  led_scan_timer #(
    .COLS         (COLS),
    .COL_CYCLES   (COL_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .col            (col),
    .blank          (blank),
    .pwm_slot       (pwm_slot),
    .frame_boundary (frame_boundary),
    .frame_start    (frame_start)
  );

`ifdef BRIGHTNESS_PWM_EN
  assign level = BRIGHTNESS;
`else
  assign level = 3'd7;
`endif

  assign dark = blank || (pwm_slot > level);
  assign swap = frame_boundary && COMMIT_PENDING;

  // The swap samples back before this edge's write lands, so a same-cycle write waits for the next commit.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < COLS; i++) begin
        front[i] <= '0;
        back[i]  <= '0;
      end
      COMMIT_PENDING <= 1'b0;
      SWAP_DONE      <= 1'b0;
    end else begin
      SWAP_DONE <= swap;
      if (WR_EN)
        back[WR_COL] <= WR_DATA;
      if (swap) begin
        for (int i = 0; i < COLS; i++)
          front[i] <= back[i];
        COMMIT_PENDING <= 1'b0;
      end else if (COMMIT) begin
        COMMIT_PENDING <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      LED_R       <= '1;
      LED_C       <= '1;
      FRAME_START <= 1'b0;
    end else begin
      FRAME_START <= frame_start;
      if (dark) begin
        LED_R <= '1;
        LED_C <= '1;
      end else begin
        LED_R <= ~front[col];
        LED_C <= ~(COLS'(1) << col);
      end
    end
  end
endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan with 16-cycle slots and 2-cycle blanking (64-cycle frames).
module tb_led_matrix_scan;
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       WR_EN = 1'b0;
  logic [1:0] WR_COL = '0;
  logic [7:0] WR_DATA = '0;
  logic       COMMIT = 1'b0;
  logic       COMMIT_PENDING, SWAP_DONE, FRAME_START;
  logic [7:0] LED_R;
  logic [3:0] LED_C;

  int n_chk = 0;
  int n_fail = 0;
  int k = 0;   // edges since reset release; outputs after edge k reflect scan position k-1

  led_matrix_scan #(.COLS(4), .ROWS(8), .COL_CYCLES(16), .BLANK_CYCLES(2)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .WR_EN          (WR_EN),
    .WR_COL         (WR_COL),
    .WR_DATA        (WR_DATA),
    .COMMIT         (COMMIT),
`ifdef BRIGHTNESS_PWM_EN
    .BRIGHTNESS     (3'd7),
`endif
    .COMMIT_PENDING (COMMIT_PENDING),
    .SWAP_DONE      (SWAP_DONE),
    .FRAME_START    (FRAME_START),
    .LED_R          (LED_R),
    .LED_C          (LED_C)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) k <= RST_N ? k + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  task automatic goto(input int t);
    while (k < t) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] c, input logic [7:0] d);
    WR_EN = 1'b1; WR_COL = c; WR_DATA = d;
    goto(k + 1);
    WR_EN = 1'b0;
  endtask

  task automatic commit_now();
    COMMIT = 1'b1;
    goto(k + 1);
    COMMIT = 1'b0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    chk("rst_led_r", LED_R, 8'hFF);
    chk("rst_led_c", LED_C, 4'hF);
    chk("rst_pend", COMMIT_PENDING, 0);
    chk("rst_swap", SWAP_DONE, 0);
    chk("rst_fs", FRAME_START, 0);
    RST_N = 1'b1;
  endtask

  initial begin
    int bad, cnt_blank, cnt_fs;
    #1;
    // 1: reset and empty-frame scan
    do_reset();
    goto(1);  chk("fs_first", FRAME_START, 1); chk("blank0_c", LED_C, 4'hF);
    goto(2);  chk("blank1_c", LED_C, 4'hF); chk("fs_pulse", FRAME_START, 0);
    goto(3);  chk("col0_c", LED_C, 4'hE); chk("col0_r_empty", LED_R, 8'hFF);
    goto(19); chk("col1_c", LED_C, 4'hD);

    // 2: fill back buffer, commit mid-frame
    goto(4);
    wr(2'd0, 8'h01); wr(2'd1, 8'h02); wr(2'd2, 8'h04); wr(2'd3, 8'h18);
    goto(10); commit_now();
    chk("pend_set", COMMIT_PENDING, 1);
    goto(40); chk("pre_swap_c", LED_C, 4'hB); chk("pre_swap_r", LED_R, 8'hFF);
    goto(63); chk("pend_bnd", COMMIT_PENDING, 1); chk("swap_early", SWAP_DONE, 0);
    goto(64); chk("swap_done", SWAP_DONE, 1); chk("pend_clr", COMMIT_PENDING, 0);
    goto(65); chk("swap_pulse", SWAP_DONE, 0); chk("fs_frame1", FRAME_START, 1);
    goto(69); chk("new_col0_r", LED_R, 8'hFE);
    goto(85); chk("new_col1_r", LED_R, 8'hFD);
    goto(118); chk("new_col3_c", LED_C, 4'h7); chk("new_col3_r", LED_R, 8'hE7);

    // 3: commit on the boundary cycle waits a full frame
    goto(100); wr(2'd2, 8'h3C);
    goto(127); chk("pend_idle", COMMIT_PENDING, 0);
    commit_now();
    chk("bnd_no_swap", SWAP_DONE, 0); chk("bnd_pend", COMMIT_PENDING, 1);
    bad = 0;
    for (int t = 128; t <= 191; t++) begin
      goto(t);
      if (COMMIT_PENDING !== 1'b1 || (t > 128 && SWAP_DONE !== 1'b0)) bad++;
    end
    chk("pend_hold", bad, 0);
    goto(192); chk("late_swap", SWAP_DONE, 1); chk("late_pend_clr", COMMIT_PENDING, 0);
    goto(229); chk("col2_new_c", LED_C, 4'hB); chk("col2_new_r", LED_R, 8'hC3);

    // 4: write on the swap cycle lands in back only
    goto(200); commit_now();
    goto(255); wr(2'd1, 8'hAA);
    chk("wr_swap_done", SWAP_DONE, 1);
    goto(277); chk("col1_keep_c", LED_C, 4'hD); chk("col1_keep_r", LED_R, 8'hFD);
    goto(280); commit_now();
    goto(341); chk("col1_aa_r", LED_R, 8'h55);

    // 5: reset while pending
    goto(345); commit_now();
    chk("pend_before_rst", COMMIT_PENDING, 1);
    do_reset();
    bad = 0;
    for (int t = 1; t <= 70; t++) begin
      goto(t);
      if (SWAP_DONE !== 1'b0 || COMMIT_PENDING !== 1'b0) bad++;
    end
    chk("no_swap_after_rst", bad, 0);
    goto(118); chk("rst_col3_c", LED_C, 4'h7); chk("rst_col3_r", LED_R, 8'hFF);

    // 6: blanking and frame-start cadence over one aligned frame
    goto(128);
    cnt_blank = 0; cnt_fs = 0;
    for (int t = 129; t <= 192; t++) begin
      goto(t);
      if (LED_C == 4'hF) cnt_blank++;
      if (FRAME_START) cnt_fs++;
      if (t == 129) chk("fs_at_129", FRAME_START, 1);
    end
    chk("blank_cycles", cnt_blank, 8);
    chk("fs_per_frame", cnt_fs, 1);
    goto(193); chk("fs_at_193", FRAME_START, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
